audio_in_demux: RTL and testbench

Host-to-synth audio path: an Avalon-MM style slave accepts left/right sample words from the host (JACK playback side), buffers them as stereo frames in an internal FIFO and releases one frame per `lrck` rising edge to the I2S/DSP domain. It is the write-direction counterpart of the existing host-read audio mux. It also exposes the fill level, a low-water interrupt and sticky error flags so the host driver can pace its writes.

---
 rtl/audio_in_demux_if.sv | 26 ++
 rtl/audio_in_demux.sv | 201 ++++++++++++++++++++
 tb/tb_audio_in_demux.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_in_demux_if.sv
// Host register bus of the audio write path (Avalon-MM style slave side).
// Handshake: read/write are 1-cycle strobes with no wait states, never both
// high together; dataout is valid the cycle after read and holds until the next read.
interface audio_in_demux_if;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] datain;
    logic [31:0] dataout;

    modport master (
        output address,
        output read,
        output write,
        output datain,
        input  dataout
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  datain,
        output dataout
    );
endinterface

// File: rtl/audio_in_demux.sv
// Host-to-synth audio path: buffers stereo frames written by the host and
// releases one frame per lrck rising edge, with level, low-water irq and error flags.
module audio_in_demux #(
    parameter int FIFO_WIDTH    = 6,
    parameter int AUD_BIT_DEPTH = 24
) (
    input  logic                     clk,
    input  logic                     reset_n,
    audio_in_demux_if.slave          host,
    input  logic                     lrck,
    output logic [AUD_BIT_DEPTH-1:0] lsound_out,
    output logic [AUD_BIT_DEPTH-1:0] rsound_out,
    output logic                     sample_valid,
    output logic [FIFO_WIDTH:0]      fifo_level,
    output logic                     underrun,
    output logic                     overflow,
    output logic                     irq
);

    localparam int FRAME_W = 2 * AUD_BIT_DEPTH;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [FRAME_W-1:0]       mem [2**FIFO_WIDTH];
    logic [FIFO_WIDTH:0]      wr_ptr;
    logic [FIFO_WIDTH:0]      rd_ptr;
    logic [FRAME_W-1:0]       head;
    logic [AUD_BIT_DEPTH-1:0] left_stage;
    logic [AUD_BIT_DEPTH-1:0] host_sample;
    logic [FIFO_WIDTH:0]      threshold;
    logic                     enable;
    logic [15:0]              underrun_cnt;
    logic [31:0]              rd_mux;

    logic lrck_meta;
    logic lrck_sync;
    logic lrck_prev;
    logic pop_req;

    logic wr_left;
    logic wr_push;
    logic wr_ctrl;
    logic wr_thr;
    logic flush;
    logic clear_flags;
    logic empty;
    logic full;
    logic pop_go;
    logic pop_ok;
    logic pop_under;
    logic push_ok;
    logic push_drop;
    logic unused_datain;

    // ------------------------------------------------------------------
    // Host write decode
    // ------------------------------------------------------------------
    assign host_sample   = host.datain[31 -: AUD_BIT_DEPTH];
    assign wr_left       = host.write && (host.address == 2'd0);
    assign wr_push       = host.write && (host.address == 2'd1);
    assign wr_ctrl       = host.write && (host.address == 2'd2);
    assign wr_thr        = host.write && (host.address == 2'd3);
    assign flush         = wr_ctrl && host.datain[2];
    assign clear_flags   = wr_ctrl && host.datain[1];
    assign unused_datain = ^host.datain;

    // ------------------------------------------------------------------
    // lrck crossing: two synchronizer flops plus one for edge detection
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lrck_meta <= 1'b0;
            lrck_sync <= 1'b0;
            lrck_prev <= 1'b0;
        end else begin
            lrck_meta <= lrck;
            lrck_sync <= lrck_meta;
            lrck_prev <= lrck_sync;
        end
    end

    assign pop_req = lrck_sync && !lrck_prev;

    // ------------------------------------------------------------------
    // FIFO status and push/pop qualification (all on pre-cycle level)
    // ------------------------------------------------------------------
    assign fifo_level = wr_ptr - rd_ptr;
    assign empty      = (fifo_level == '0);
    assign full       = fifo_level[FIFO_WIDTH];

    // A flush shares the cycle only with a pop (push is another address), and discards it.
    assign pop_go    = pop_req && enable && !flush;
    assign pop_ok    = pop_go && !empty;
    assign pop_under = pop_go && empty;
    assign push_ok   = wr_push && !full;
    assign push_drop = wr_push && full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[FIFO_WIDTH-1:0]] <= {left_stage, host_sample};
    end

    assign head = mem[rd_ptr[FIFO_WIDTH-1:0]];

    // ------------------------------------------------------------------
    // Sample outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lsound_out   <= '0;
            rsound_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= pop_ok || pop_under;
            if (!enable || pop_under) begin
                lsound_out <= '0;
                rsound_out <= '0;
            end else if (pop_ok) begin
                lsound_out <= head[FRAME_W-1 -: AUD_BIT_DEPTH];
                rsound_out <= head[AUD_BIT_DEPTH-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Error flags; a new event in the clear cycle wins over the clear
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun     <= 1'b0;
            overflow     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            if (pop_under)        underrun <= 1'b1;
            else if (clear_flags) underrun <= 1'b0;

            if (push_drop)        overflow <= 1'b1;
            else if (clear_flags) overflow <= 1'b0;

            if (pop_under) begin
                if (clear_flags)                  underrun_cnt <= 16'd1;
                else if (underrun_cnt != CNT_MAX) underrun_cnt <= underrun_cnt + 16'd1;
            end else if (clear_flags) begin
                underrun_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            left_stage <= '0;
            enable     <= 1'b0;
            threshold  <= '0;
        end else begin
            if (flush)        left_stage <= '0;
            else if (wr_left) left_stage <= host_sample;

            if (wr_ctrl) enable    <= host.datain[0];
            if (wr_thr)  threshold <= host.datain[FIFO_WIDTH:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq <= 1'b0;
        else          irq <= enable && (fifo_level <= threshold);
    end

    // ------------------------------------------------------------------
    // Host read path
    // ------------------------------------------------------------------
    always_comb begin
        rd_mux = '0;
        unique case (host.address)
            2'd0: rd_mux[FIFO_WIDTH:0] = fifo_level;
            2'd1: rd_mux = {underrun_cnt, 13'b0, enable, overflow, underrun};
            2'd2: rd_mux = {31'b0, enable};
            2'd3: rd_mux[FIFO_WIDTH:0] = threshold;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       host.dataout <= '0;
        else if (host.read) host.dataout <= rd_mux;
    end

endmodule

// File: tb/tb_audio_in_demux.sv
// Bench for audio_in_demux: directed scenarios plus random traffic, checked
// every cycle against a queue-based behavioural model.
module tb_audio_in_demux;
  localparam int FW = 6;
  localparam int AW = 24;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic lrck = 1'b0;
  logic [AW-1:0] lsound_out;
  logic [AW-1:0] rsound_out;
  logic sample_valid;
  logic [FW:0] fifo_level;
  logic underrun;
  logic overflow;
  logic irq;

  audio_in_demux_if bus();

  audio_in_demux #(.FIFO_WIDTH(FW), .AUD_BIT_DEPTH(AW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .host(bus),
    .lrck(lrck),
    .lsound_out(lsound_out),
    .rsound_out(rsound_out),
    .sample_valid(sample_valid),
    .fifo_level(fifo_level),
    .underrun(underrun),
    .overflow(overflow),
    .irq(irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // behavioural model: frames queued as {left,right}
  logic [2*AW-1:0] exp_q[$];
  logic [AW-1:0] got_l_q[$];
  logic [AW-1:0] m_left = '0;
  logic [AW-1:0] m_l = '0;
  logic [AW-1:0] m_r = '0;
  logic m_sv = 1'b0;
  logic m_en = 1'b0;
  logic m_und = 1'b0;
  logic m_ovf = 1'b0;
  logic m_irq = 1'b0;
  logic [15:0] m_cnt = '0;
  logic [FW:0] m_thr = '0;
  logic [31:0] m_dout = '0;
  logic m_rd_seen = 1'b0;
  logic [2:0] m_hist = '0;

  logic [FW:0] t_lvl;
  logic t_pop, t_flush, t_clr, t_push, t_und, t_ovf, t_en_pre;
  logic [AW-1:0] t_smp;
  logic [2*AW-1:0] t_f;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      m_left = '0; m_l = '0; m_r = '0; m_sv = 1'b0; m_en = 1'b0;
      m_und = 1'b0; m_ovf = 1'b0; m_irq = 1'b0; m_cnt = '0; m_thr = '0;
      m_dout = '0; m_rd_seen = 1'b0; m_hist = '0;
    end else begin
      t_lvl = (FW+1)'(exp_q.size());
      t_en_pre = m_en;
      // a pop lands two edges after lrck is first seen high
      t_pop = m_en && m_hist[1] && !m_hist[2];
      t_smp = bus.datain[31:8];
      t_push = bus.write && (bus.address == 2'd1);
      t_flush = bus.write && (bus.address == 2'd2) && bus.datain[2];
      t_clr = bus.write && (bus.address == 2'd2) && bus.datain[1];
      t_und = 1'b0;
      t_ovf = 1'b0;

      m_rd_seen = bus.read;
      if (bus.read) begin
        case (bus.address)
          2'd0: m_dout = {25'b0, t_lvl};
          2'd1: m_dout = {m_cnt, 13'b0, m_en, m_ovf, m_und};
          2'd2: m_dout = {31'b0, m_en};
          default: m_dout = {25'b0, m_thr};
        endcase
      end
      m_irq = m_en && (t_lvl <= m_thr);

      m_sv = 1'b0;
      if (t_flush) t_pop = 1'b0;
      if (t_pop) begin
        m_sv = 1'b1;
        if (t_lvl != 0) begin
          t_f = exp_q.pop_front();
          m_l = t_f[2*AW-1:AW];
          m_r = t_f[AW-1:0];
        end else begin
          m_l = '0; m_r = '0; t_und = 1'b1;
        end
      end
      if (!t_en_pre) begin m_l = '0; m_r = '0; end

      if (t_push) begin
        if (t_lvl == (FW+1)'(DEPTH)) t_ovf = 1'b1;
        else exp_q.push_back({m_left, t_smp});
      end
      if (t_flush) begin exp_q.delete(); m_left = '0; end
      if (bus.write && bus.address == 2'd0) m_left = t_smp;
      if (bus.write && bus.address == 2'd2) m_en = bus.datain[0];
      if (bus.write && bus.address == 2'd3) m_thr = bus.datain[FW:0];

      if (t_clr) begin m_und = 1'b0; m_ovf = 1'b0; m_cnt = '0; end
      if (t_und) begin
        m_und = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      if (t_ovf) m_ovf = 1'b1;
      m_hist = {m_hist[1:0], lrck};
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    checks++;
    if ({lsound_out, rsound_out, sample_valid, fifo_level, underrun, overflow, irq} !==
        {m_l, m_r, m_sv, (FW+1)'(exp_q.size()), m_und, m_ovf, m_irq}) begin
      errors++;
      $display("FAIL outputs t=%0t got l=%h r=%h sv=%b lvl=%0d und=%b ovf=%b irq=%b exp l=%h r=%h sv=%b lvl=%0d und=%b ovf=%b irq=%b",
               $time, lsound_out, rsound_out, sample_valid, fifo_level, underrun, overflow, irq,
               m_l, m_r, m_sv, exp_q.size(), m_und, m_ovf, m_irq);
    end
    if (m_rd_seen) begin
      checks++;
      if (bus.dataout !== m_dout) begin
        errors++;
        $display("FAIL dataout t=%0t got=%h exp=%h", $time, bus.dataout, m_dout);
      end
    end
    if (sample_valid) got_l_q.push_back(lsound_out);
  end

  // driver tasks (inputs change 1 time unit after the falling edge)
  task automatic step(input logic w, input logic r, input logic [1:0] a, input logic [31:0] d);
    bus.write = w;
    bus.read = r;
    bus.address = a;
    bus.datain = d;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [1:0] a);
    step(1'b0, 1'b1, a, 32'd0);
  endtask

  task automatic lrck_edge();
    lrck = 1'b1;
    idle(2);
    lrck = 1'b0;
    idle(2);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(1);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  logic [23:0] v;
  logic [31:0] d;
  int bad;
  int push_pct;
  int op;

  initial begin
    bus.write = 1'b0; bus.read = 1'b0; bus.address = 2'd0; bus.datain = 32'd0;
    @(negedge clk);
    #1;

    // reset state
    do_reset();
    check("reset_level", 32'(fifo_level), 32'd0);
    check("reset_flags", {29'b0, underrun, overflow, irq}, 32'd0);

    // underrun with no data
    wr(2'd2, 32'd1);
    got_l_q.delete();
    repeat (3) lrck_edge();
    check("s1_sv_count", 32'(got_l_q.size()), 32'd3);
    check("s1_underrun", {31'b0, underrun}, 32'd1);
    rd(2'd1);
    check("s1_status", bus.dataout, 32'h0003_0005);

    // single frame
    do_reset();
    wr(2'd0, 32'h1234_5600);
    wr(2'd1, 32'hABCD_EF00);
    check("s2_level", 32'(fifo_level), 32'd1);
    wr(2'd2, 32'd1);
    lrck = 1'b1;
    idle(3);
    check("s2_left", 32'(lsound_out), 32'h0012_3456);
    check("s2_right", 32'(rsound_out), 32'h00AB_CDEF);
    check("s2_level0", 32'(fifo_level), 32'd0);
    lrck = 1'b0;
    idle(2);

    // fill past full while disabled, then drain in order
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      v = 24'(i);
      wr(2'd0, {v, 8'h00});
      wr(2'd1, {~v, 8'h00});
    end
    check("s3_level_full", 32'(fifo_level), 32'd64);
    check("s3_overflow", {31'b0, overflow}, 32'd1);
    wr(2'd2, 32'd1);
    got_l_q.delete();
    repeat (DEPTH) lrck_edge();
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (i >= got_l_q.size() || got_l_q[i] !== 24'(i)) bad++;
    check("s3_order_bad", 32'(bad), 32'd0);
    check("s3_underrun_before", {31'b0, underrun}, 32'd0);
    lrck_edge();
    check("s3_underrun_65th", {31'b0, underrun}, 32'd1);

    // low-water irq
    do_reset();
    wr(2'd3, 32'd4);
    wr(2'd2, 32'd1);
    repeat (6) wr(2'd1, 32'h1111_1100);
    idle(1);
    check("s4_irq_l6", {31'b0, irq}, 32'd0);
    lrck_edge();
    check("s4_irq_l5", {31'b0, irq}, 32'd0);
    lrck_edge();
    check("s4_irq_l4", {31'b0, irq}, 32'd1);
    lrck_edge();
    check("s4_irq_l3", {31'b0, irq}, 32'd1);
    wr(2'd1, 32'h2222_2200);
    wr(2'd1, 32'h3333_3300);
    idle(1);
    check("s4_level5", 32'(fifo_level), 32'd5);
    check("s4_irq_back5", {31'b0, irq}, 32'd0);

    // push and pop in the same cycle at full, then flush and clear
    do_reset();
    repeat (DEPTH) wr(2'd1, 32'h5555_5500);
    wr(2'd2, 32'd1);
    lrck = 1'b1;
    idle(2);
    wr(2'd1, 32'hDEAD_BE00);
    check("s5_level63", 32'(fifo_level), 32'd63);
    check("s5_overflow", {31'b0, overflow}, 32'd1);
    lrck = 1'b0;
    idle(2);
    wr(2'd2, 32'd5);
    check("s5_flush_level", 32'(fifo_level), 32'd0);
    check("s5_flush_flags", {30'b0, overflow, underrun}, 32'd2);
    wr(2'd2, 32'd3);
    check("s5_cleared", {30'b0, overflow, underrun}, 32'd0);

    // reset with a pop in flight
    do_reset();
    wr(2'd2, 32'd1);
    repeat (10) wr(2'd1, 32'h7777_7700);
    check("s6_level10", 32'(fifo_level), 32'd10);
    got_l_q.delete();
    lrck = 1'b1;
    idle(1);
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(4);
    check("s6_no_sv", 32'(got_l_q.size()), 32'd0);
    check("s6_level0", 32'(fifo_level), 32'd0);
    check("s6_outputs", {8'b0, lsound_out}, 32'd0);
    lrck = 1'b0;
    idle(2);

    // random traffic: filling phase then draining phase
    do_reset();
    wr(2'd2, 32'd1);
    for (int ph = 0; ph < 2; ph++) begin
      push_pct = (ph == 0) ? 30 : 8;
      repeat (1500) begin
        if ($urandom_range(0, 3) == 0) lrck = ~lrck;
        op = $urandom_range(0, 99);
        if (op < push_pct) wr(2'd1, $urandom);
        else if (op < push_pct + 15) wr(2'd0, $urandom);
        else if (op < push_pct + 25) rd(2'($urandom_range(0, 3)));
        else if (op < push_pct + 28) wr(2'd3, $urandom);
        else if (op < push_pct + 32) begin
          d = $urandom;
          d[0] = ($urandom_range(0, 4) != 0);
          d[2] = ($urandom_range(0, 7) == 0);
          wr(2'd2, d);
        end else idle(1);
      end
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
